// File: rtl/alu_seq_if.sv
// Operation request and result bundle for alu_seq.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 13
);
  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sel, a, b,
    input  result, done, busy, zero, carry, overflow
  );

  modport slave (
    input  start, sel, a, b,
    output result, done, busy, zero, carry, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts.
module alu_seq #(
  parameter int unsigned WIDTH = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             op_ovf;
  logic             op_long;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;

  assign sum       = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff      = bus.a - bus.b;
  assign shifted   = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
  assign shift_out = left_q ? acc_q[WIDTH-1] : acc_q[0];

  // Decode the requested operation; op_long marks shifts that need the serial path.
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    op_long  = 1'b0;
    unique case (bus.sel)
      3'b000, 3'b100: begin
        op_res   = sum[WIDTH-1:0];
        op_carry = sum[WIDTH];
        op_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b001, 3'b101: begin
        op_res   = diff;
        op_carry = bus.a < bus.b;
        op_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b010, 3'b011: begin
        // b == 0 passes a through; b >= WIDTH shifts everything out (result stays 0).
        if (bus.b == '0) begin
          op_res = bus.a;
        end else if (bus.b < WidthVal) begin
          op_long = 1'b1;
        end
      end
      3'b110: op_res = bus.a & bus.b;
      3'b111: op_res = bus.a | bus.b;
      default: ;
    endcase
  end

  // Next-state: accept in IDLE/DONE, step the shifter in SHIFT, load results on DONE entry.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      StShift: begin
        acc_d = shifted;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          res_d   = shifted;
          zero_d  = (shifted == '0);
          carry_d = shift_out;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        if (bus.start) begin
          if (op_long) begin
            state_d = StShift;
            acc_d   = bus.a;
            cnt_d   = bus.b[CntW-1:0];
            left_d  = bus.sel[0];
          end else begin
            state_d = StDone;
            res_d   = op_res;
            zero_d  = (op_res == '0);
            carry_d = op_carry;
            ovf_d   = op_ovf;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = (state_q == StDone);
  assign bus.busy     = (state_q == StShift);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized traffic
// checked every cycle against an edge-count based behavioural model.
module tb_alu_seq;

  localparam int W = 13;
  localparam longint M = 64'd1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic from the opcode rules, in plain integers.
  function automatic void ref_op(input int s, input longint a, input longint b,
                                 output longint r, output bit z, output bit c,
                                 output bit v, output bit lg);
    longint sa, sb, st;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    r = 0; c = 0; v = 0; lg = 0;
    case (s)
      0, 4: begin
        r  = (a + b) % M;
        c  = (a + b) >= M;
        st = sa + sb;
        v  = (st > M / 2 - 1) || (st < -(M / 2));
      end
      1, 5: begin
        r  = (a - b + M) % M;
        c  = a < b;
        st = sa - sb;
        v  = (st > M / 2 - 1) || (st < -(M / 2));
      end
      2: begin
        if (b == 0) r = a;
        else if (b < W) begin
          r = a >> b; c = ((a >> (b - 1)) & 1) != 0; lg = 1;
        end
      end
      3: begin
        if (b == 0) r = a;
        else if (b < W) begin
          r = (a << b) % M; c = ((a >> (W - b)) & 1) != 0; lg = 1;
        end
      end
      6: r = a & b;
      default: r = a | b;
    endcase
    z = (r == 0);
  endfunction

  // Model: tracks rising-edge index of acceptance and completion.
  longint e = 0, done_edge = -1, acc_edge = 0, free_edge = 0;
  longint p_res = 0, s_res = 0, t_res;
  bit p_z, p_c, p_v, s_z = 0, s_c = 0, s_v = 0, t_z, t_c, t_v, t_lg;
  bit x_done = 0, x_busy = 0;

  // Model update on each rising edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_edge = -1; acc_edge = 0; free_edge = 0;
      s_res = 0; s_z = 0; s_c = 0; s_v = 0;
      x_done = 0; x_busy = 0;
    end else begin
      e++;
      if (bus.start && e >= free_edge) begin
        ref_op(int'(bus.sel), longint'(bus.a), longint'(bus.b), t_res, t_z, t_c, t_v, t_lg);
        p_res = t_res; p_z = t_z; p_c = t_c; p_v = t_v;
        acc_edge  = e;
        done_edge = t_lg ? e + longint'(bus.b) : e;
        free_edge = done_edge + 1;
      end
      x_done = (e == done_edge);
      x_busy = (e >= acc_edge) && (e < done_edge);
      if (x_done) begin
        s_res = p_res; s_z = p_z; s_c = p_c; s_v = p_v;
      end
    end
  end

  bit chk_on = 0;

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_done",     longint'(bus.done),     longint'(x_done));
      chk("cyc_busy",     longint'(bus.busy),     longint'(x_busy));
      chk("cyc_result",   longint'(bus.result),   s_res);
      chk("cyc_zero",     longint'(bus.zero),     longint'(s_z));
      chk("cyc_carry",    longint'(bus.carry),    longint'(s_c));
      chk("cyc_overflow", longint'(bus.overflow), longint'(s_v));
    end
  end

  task automatic op(input logic [2:0] s, input longint av, input longint bv);
    @(negedge clk);
    bus.start = 1'b1; bus.sel = s; bus.a = W'(av); bus.b = W'(bv);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int nd;

  initial begin
    bus.start = 1'b0; bus.sel = 3'd0; bus.a = '0; bus.b = '0;
    #1;
    chk_on = 1;
    chk("reset_result", longint'(bus.result), 0);
    chk("reset_done",   longint'(bus.done), 0);
    chk("reset_busy",   longint'(bus.busy), 0);
    chk("reset_flags",  longint'({bus.zero, bus.carry, bus.overflow}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Add wrapping to zero.
    op(3'b000, 'h1FFF, 1);
    chk("add_done", longint'(bus.done), 1);
    chk("add_result", longint'(bus.result), 0);
    chk("add_zcv", longint'({bus.zero, bus.carry, bus.overflow}), 'b110);

    // Subtract with borrow, then signed overflow.
    op(3'b001, 5, 7);
    chk("sub1_result", longint'(bus.result), 'h1FFE);
    chk("sub1_cv", longint'({bus.carry, bus.overflow}), 'b10);
    op(3'b101, 'h0FFF, 'h1FFF);
    chk("sub2_result", longint'(bus.result), 'h1000);
    chk("sub2_ovf", longint'(bus.overflow), 1);

    // Shift left by 4 with start held high; input changes mid-shift are ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 3'b011; bus.a = W'('h0003); bus.b = W'(4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("shl_busy", longint'(bus.busy), 1);
      chk("shl_nodone", longint'(bus.done), 0);
      if (k == 2) begin
        bus.sel = 3'b000; bus.a = W'('h1FFF); bus.b = W'(2);
      end
    end
    @(negedge clk);
    chk("shl_done", longint'(bus.done), 1);
    chk("shl_result", longint'(bus.result), 'h0030);
    chk("shl_carry", longint'(bus.carry), 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("shl_single_done", longint'(bus.done), 0);

    // Shift right by WIDTH and by zero.
    op(3'b010, 'h1234, 13);
    chk("srl13_result", longint'(bus.result), 0);
    chk("srl13_zc", longint'({bus.zero, bus.carry}), 'b10);
    chk("srl13_busy", longint'(bus.busy), 0);
    chk("srl13_done", longint'(bus.done), 1);
    op(3'b010, 'h1234, 0);
    chk("srl0_result", longint'(bus.result), 'h1234);

    // Reset in the middle of a 6-step shift aborts it.
    op(3'b010, 'h0ABC, 6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", longint'(bus.result), 0);
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_done", longint'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort_no_done", longint'(nd), 0);
    op(3'b110, 'h0F0F, 'h00FF);
    chk("and_result", longint'(bus.result), 'h000F);
    chk("and_done", longint'(bus.done), 1);

    // OR accepted in the DONE cycle of an add.
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 3'b000; bus.a = W'(100); bus.b = W'(23);
    @(negedge clk);
    chk("b2b_add_done", longint'(bus.done), 1);
    chk("b2b_add_result", longint'(bus.result), 123);
    bus.sel = 3'b111; bus.a = W'('h0F00); bus.b = W'('h00F0);
    @(negedge clk);
    chk("b2b_or_done", longint'(bus.done), 1);
    chk("b2b_or_result", longint'(bus.result), 'h0FF0);
    bus.start = 1'b0;

    // Random traffic, occasional asynchronous reset pulses.
    repeat (600) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.sel   = 3'($urandom_range(0, 7));
      bus.a     = W'($urandom);
      bus.b     = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
